// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU controller and instruction decoder: FSM states,
// opcode/op encodings, register-select and writeback-source codes.
package cpu_pkg;

  typedef enum logic [3:0] {
    StWait,
    StDecode,
    StGetA,
    StGetB,
    StExec,
    StCmp,
    StWriteReg,
    StWriteImm,
    StHalt
  } state_e;

  typedef enum logic [2:0] {
    InsIllegal,
    InsMovImm,
    InsMovReg,
    InsAdd,
    InsAnd,
    InsCmp,
    InsMvn
  } instr_e;

  localparam logic [2:0] OpcMov = 3'b110;
  localparam logic [2:0] OpcAlu = 3'b101;

  localparam logic [1:0] OpMovImm = 2'b10;
  localparam logic [1:0] OpMovReg = 2'b00;
  localparam logic [1:0] OpAdd    = 2'b00;
  localparam logic [1:0] OpCmp    = 2'b01;
  localparam logic [1:0] OpAnd    = 2'b10;
  localparam logic [1:0] OpMvn    = 2'b11;

  localparam logic [2:0] NselNone = 3'b000;
  localparam logic [2:0] NselRn   = 3'b001;
  localparam logic [2:0] NselRd   = 3'b010;
  localparam logic [2:0] NselRm   = 3'b100;

  localparam logic [1:0] VselC   = 2'b00;
  localparam logic [1:0] VselImm = 2'b01;

  // Classify an opcode/op pair; anything unlisted is illegal.
  function automatic instr_e decode_instr(logic [2:0] opcode, logic [1:0] op);
    case ({opcode, op})
      {OpcMov, OpMovImm}: return InsMovImm;
      {OpcMov, OpMovReg}: return InsMovReg;
      {OpcAlu, OpAdd}:    return InsAdd;
      {OpcAlu, OpAnd}:    return InsAnd;
      {OpcAlu, OpCmp}:    return InsCmp;
      {OpcAlu, OpMvn}:    return InsMvn;
      default:            return InsIllegal;
    endcase
  endfunction

endpackage

// File: rtl/cpu_controller_if.sv
// Bundle of the controller's instruction inputs and datapath control outputs.
// master: the decoder side driving s/opcode/op; slave: the controller.
interface cpu_controller_if;
  logic       s;
  logic [2:0] opcode;
  logic [1:0] op;
  logic       w;
  logic [2:0] nsel;
  logic       loada;
  logic       loadb;
  logic       loadc;
  logic       loads;
  logic       write;
  logic       asel;
  logic       bsel;
  logic [1:0] vsel;
  logic       halt;

  modport master (
    output s, opcode, op,
    input  w, nsel, loada, loadb, loadc, loads, write, asel, bsel, vsel, halt
  );

  modport slave (
    input  s, opcode, op,
    output w, nsel, loada, loadb, loadc, loads, write, asel, bsel, vsel, halt
  );
endinterface

// File: rtl/cpu_controller.sv
// Moore FSM sequencing the datapath strobes for MOV/ALU instructions.
// Optional macro CPU_CTRL_ILLEGAL_TRAP_EN: illegal instructions trap in HALT
// (left only by reset); when undefined they return to WAIT and halt is tied 0.
module cpu_controller
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       s,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic       w,
  output logic [2:0] nsel,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       write,
  output logic       asel,
  output logic       bsel,
  output logic [1:0] vsel,
  output logic       halt
);

  state_e     r_state;
  state_e     w_state_next;
  logic [2:0] r_opcode;
  logic [1:0] r_op;
  instr_e     w_instr;

  assign w_instr = decode_instr(r_opcode, r_op);

  // State register and instruction capture; reset takes priority over s.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= StWait;
      r_opcode <= '0;
      r_op     <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == StWait && s) begin
        r_opcode <= opcode;
        r_op     <= op;
      end
    end
  end

  // Next-state sequencing of the captured instruction.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StWait:     if (s) w_state_next = StDecode;
      StDecode: begin
        case (w_instr)
          InsMovImm:              w_state_next = StWriteImm;
          InsMovReg, InsMvn:      w_state_next = StGetB;
          InsAdd, InsAnd, InsCmp: w_state_next = StGetA;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
          default:                w_state_next = StHalt;
`else
          default:                w_state_next = StWait;
`endif
        endcase
      end
      StGetA:     w_state_next = StGetB;
      StGetB:     w_state_next = (w_instr == InsCmp) ? StCmp : StExec;
      StExec:     w_state_next = StWriteReg;
      StCmp:      w_state_next = StWait;
      StWriteReg: w_state_next = StWait;
      StWriteImm: w_state_next = StWait;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
      StHalt:     w_state_next = StHalt;
`else
      StHalt:     w_state_next = StWait;
`endif
      default:    w_state_next = StWait;
    endcase
  end

  // Moore output decode; everything defaults to inactive.
  always_comb begin
    w     = 1'b0;
    nsel  = NselNone;
    loada = 1'b0;
    loadb = 1'b0;
    loadc = 1'b0;
    loads = 1'b0;
    write = 1'b0;
    asel  = 1'b0;
    bsel  = 1'b0;
    vsel  = VselC;
    halt  = 1'b0;
    case (r_state)
      StWait: w = 1'b1;
      StGetA: begin
        nsel  = NselRn;
        loada = 1'b1;
      end
      StGetB: begin
        nsel  = NselRm;
        loadb = 1'b1;
      end
      StExec: begin
        loadc = 1'b1;
        // Single-operand ops pass B through with A forced to zero.
        asel  = (w_instr == InsMovReg) || (w_instr == InsMvn);
      end
      StCmp: loads = 1'b1;
      StWriteReg: begin
        nsel  = NselRd;
        write = 1'b1;
        vsel  = VselC;
      end
      StWriteImm: begin
        nsel  = NselRn;
        write = 1'b1;
        vsel  = VselImm;
      end
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
      StHalt: halt = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Scoreboard bench for cpu_controller: stimulus pushes per-cycle expected output
// vectors tagged with a cycle number; a negedge monitor pops and compares them.
module tb_cpu_controller;

  // Packed output vector: {w, nsel, loada, loadb, loadc, loads, write, asel, bsel, vsel, halt}
  localparam logic [13:0] V_WAIT  = 14'b1_000_0000000_00_0;
  localparam logic [13:0] V_DEC   = 14'b0_000_0000000_00_0;
  localparam logic [13:0] V_GETA  = 14'b0_001_1000000_00_0;
  localparam logic [13:0] V_GETB  = 14'b0_100_0100000_00_0;
  localparam logic [13:0] V_EXEC  = 14'b0_000_0010000_00_0;
  localparam logic [13:0] V_EXECA = 14'b0_000_0010010_00_0;
  localparam logic [13:0] V_CMP   = 14'b0_000_0001000_00_0;
  localparam logic [13:0] V_WREG  = 14'b0_010_0000100_00_0;
  localparam logic [13:0] V_WIMM  = 14'b0_001_0000100_01_0;
  localparam logic [13:0] V_HALT  = 14'b0_000_0000000_00_1;

  typedef struct {
    int          cyc;
    logic [13:0] v;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t exp_q[$];
  logic [13:0] seq_q[$];
  string tname;
  logic [13:0] act;

  cpu_controller_if bus();

  cpu_controller dut (
    .clk    (clk),
    .reset  (reset),
    .s      (bus.s),
    .opcode (bus.opcode),
    .op     (bus.op),
    .w      (bus.w),
    .nsel   (bus.nsel),
    .loada  (bus.loada),
    .loadb  (bus.loadb),
    .loadc  (bus.loadc),
    .loads  (bus.loads),
    .write  (bus.write),
    .asel   (bus.asel),
    .bsel   (bus.bsel),
    .vsel   (bus.vsel),
    .halt   (bus.halt)
  );

  assign act = {bus.w, bus.nsel, bus.loada, bus.loadb, bus.loadc, bus.loads, bus.write,
                bus.asel, bus.bsel, bus.vsel, bus.halt};

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation due in the current cycle.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      total++;
      if (e.cyc != cyc || act !== e.v) begin
        bad++;
        $display("FAIL %s cyc=%0d: got %b required %b (due cyc %0d)",
                 e.name, cyc, act, e.v, e.cyc);
      end
    end
  end

  task automatic push(input int c, input logic [13:0] v);
    exp_t e;
    e.cyc  = c;
    e.v    = v;
    e.name = tname;
    exp_q.push_back(e);
  endtask

  // Called #1 after a posedge; reset is asserted together with s to show priority.
  task automatic do_reset();
    bus.s      = 1'b1;
    bus.opcode = 3'b101;
    bus.op     = 2'b00;
    reset      = 1'b1;
    @(posedge clk);
    #1;
    push(cyc, V_WAIT);
    push(cyc + 1, V_WAIT);
    reset = 1'b0;
    bus.s = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Called #1 after a posedge while in WAIT; seq_q holds the states from DECODE on.
  task automatic issue(input logic [2:0] opc, input logic [1:0] o, input bit hold_s,
                       input bit scramble);
    int base;
    int n;
    n          = seq_q.size();
    base       = cyc;
    bus.s      = 1'b1;
    bus.opcode = opc;
    bus.op     = o;
    for (int i = 0; i < n; i++) push(base + 1 + i, seq_q[i]);
    push(base + 1 + n, V_WAIT);
    @(posedge clk);
    #1;
    if (!hold_s) bus.s = 1'b0;
    if (scramble) begin
      bus.opcode = 3'b110;
      bus.op     = 2'b10;
    end
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    reset      = 1'b1;
    bus.s      = 1'b0;
    bus.opcode = 3'b000;
    bus.op     = 2'b00;
    tname      = "reset_state";
    @(posedge clk);
    #1;
    do_reset();

    tname = "mov_imm";
    seq_q = '{V_DEC, V_WIMM};
    issue(3'b110, 2'b10, 1'b0, 1'b0);

    tname = "add";
    seq_q = '{V_DEC, V_GETA, V_GETB, V_EXEC, V_WREG};
    issue(3'b101, 2'b00, 1'b0, 1'b0);

    tname = "and";
    issue(3'b101, 2'b10, 1'b0, 1'b0);

    tname = "add_opcode_changed";
    issue(3'b101, 2'b00, 1'b0, 1'b1);

    tname = "cmp";
    seq_q = '{V_DEC, V_GETA, V_GETB, V_CMP};
    issue(3'b101, 2'b01, 1'b0, 1'b0);

    tname = "mvn";
    seq_q = '{V_DEC, V_GETB, V_EXECA, V_WREG};
    issue(3'b101, 2'b11, 1'b0, 1'b0);

    tname = "mov_reg";
    issue(3'b110, 2'b00, 1'b0, 1'b0);

    // s held high across back-to-back instructions.
    tname = "b2b_mov_imm";
    seq_q = '{V_DEC, V_WIMM};
    issue(3'b110, 2'b10, 1'b1, 1'b0);
    tname = "b2b_cmp";
    seq_q = '{V_DEC, V_GETA, V_GETB, V_CMP};
    issue(3'b101, 2'b01, 1'b0, 1'b0);

    // Reset during EXEC of an ADD.
    tname      = "reset_in_exec";
    base       = cyc;
    bus.s      = 1'b1;
    bus.opcode = 3'b101;
    bus.op     = 2'b00;
    push(base + 1, V_DEC);
    push(base + 2, V_GETA);
    push(base + 3, V_GETB);
    push(base + 4, V_EXEC);
    @(posedge clk);
    #1;
    bus.s = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    push(cyc, V_WAIT);
    push(cyc + 1, V_WAIT);
    @(posedge clk);
    #1;

`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
    tname      = "illegal_halt";
    base       = cyc;
    bus.s      = 1'b1;
    bus.opcode = 3'b111;
    bus.op     = 2'b00;
    push(base + 1, V_DEC);
    for (int i = 2; i <= 13; i++) push(base + i, V_HALT);
    @(posedge clk);
    #1;
    bus.opcode = 3'b110;
    bus.op     = 2'b10;
    repeat (12) @(posedge clk);
    #1;
    tname = "reset_from_halt";
    do_reset();
`else
    tname = "illegal_111";
    seq_q = '{V_DEC};
    issue(3'b111, 2'b00, 1'b0, 1'b0);
    tname = "illegal_110_01";
    issue(3'b110, 2'b01, 1'b0, 1'b0);
`endif

    tname = "mov_imm_after";
    seq_q = '{V_DEC, V_WIMM};
    issue(3'b110, 2'b10, 1'b0, 1'b0);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_controller.md
CPU_CONTROLLER -- requirements
Module: cpu_controller

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes occur on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port s, input, 1 bit: start request, sampled only in WAIT.
REQ-004 SHALL have port opcode, input, 3 bits: instruction class from the decoder (110 = MOV, 101 = ALU).
REQ-005 SHALL have port op, input, 2 bits: sub-operation from the decoder.
REQ-006 SHALL have port w, output, 1 bit: high only while in WAIT.
REQ-007 SHALL have port nsel, output, 3 bits: one-hot register select to the decoder (001 = Rn, 010 = Rd, 100 = Rm, 000 = none).
REQ-008 SHALL have outputs loada, loadb, loadc, loads, write, asel and bsel, 1 bit each: datapath strobes and selects.
REQ-009 SHALL have port vsel, output, 2 bits: writeback source (00 = C, 01 = sximm8).
REQ-010 SHALL have port halt, output, 1 bit: illegal-instruction indicator.

Function
REQ-011 SHALL be a Moore FSM with states WAIT, DECODE, GET_A, GET_B, EXEC, CMP, WRITE_REG, WRITE_IMM and HALT; every state other than WAIT and HALT SHALL last exactly one cycle.
REQ-012 SHALL move WAIT to DECODE on an edge where s=1, and SHALL capture opcode and op into internal registers on that edge; input changes after that edge SHALL be ignored until the next WAIT.
REQ-013 SHALL ignore s in every state except WAIT.
REQ-014 SHALL sequence the captured instruction as follows:
- MOV imm (110/10): DECODE, WRITE_IMM, WAIT.
- MOV reg (110/00): DECODE, GET_B, EXEC, WRITE_REG, WAIT.
- ADD (101/00) and AND (101/10): DECODE, GET_A, GET_B, EXEC, WRITE_REG, WAIT.
- CMP (101/01): DECODE, GET_A, GET_B, CMP, WAIT.
- MVN (101/11): DECODE, GET_B, EXEC, WRITE_REG, WAIT.
REQ-015 SHALL drive outputs per state as follows; every output not listed for a state SHALL be 0:
- GET_A: nsel=001, loada=1.
- GET_B: nsel=100, loadb=1.
- EXEC: loadc=1; asel=1 for MOV reg and MVN.
- CMP: loads=1; asel and bsel 0.
- WRITE_REG: nsel=010, write=1, vsel=00.
- WRITE_IMM: nsel=001, write=1, vsel=01.
REQ-016 SHALL give latency from the s-accepting edge to w=1 of 3 cycles (MOV imm), 5 (MOV reg, MVN, CMP) and 6 (ADD, AND).
REQ-017 SHALL treat any other opcode/op combination as illegal and leave DECODE per REQ-025.
REQ-018 SHALL, when s is held high continuously, spend exactly one cycle in WAIT with w=1 between instructions.

Reset
REQ-019 SHALL, on an edge with reset=1, enter WAIT from any state, including mid-sequence and HALT.
REQ-020 SHALL, in the cycle after reset, drive w=1 and all other outputs (nsel, strobes, selects, vsel, halt) to 0.
REQ-021 SHALL give reset priority over s.
REQ-022 SHALL never assert write in the cycle following a reset edge.

Configuration
REQ-023 SHALL use the macro CPU_CTRL_ILLEGAL_TRAP_EN.
REQ-024 SHALL, when CPU_CTRL_ILLEGAL_TRAP_EN is defined, move an illegal instruction DECODE to HALT; HALT SHALL hold halt=1 and all strobes 0, and SHALL leave only on reset.
REQ-025 SHALL, when CPU_CTRL_ILLEGAL_TRAP_EN is undefined, move an illegal instruction DECODE to WAIT with no strobes, keep HALT unreachable, and tie halt to 0.

Structure
REQ-026 SHALL place the state enum, opcode/op constants and the nsel and vsel codes in shared package cpu_pkg, which the decoder also imports.
REQ-027 SHALL be a single module with no sub-module: next-state logic and the output decode SHALL both be always blocks in cpu_controller.

Verification
REQ-028 SHALL cover: reset, then s=1 with 110/10 -> one WRITE_IMM cycle with nsel=001, write=1, vsel=01; w=1 again 3 cycles after the accepting edge.
REQ-029 SHALL cover: ADD 101/00 -> loada cycle with nsel=001, then loadb with nsel=100, loadc, write with nsel=010; w returns after 6 cycles.
REQ-030 SHALL cover: CMP 101/01 -> exactly one loads pulse and no write pulse for the whole sequence.
REQ-031 SHALL cover: opcode changed to 110 in the cycle after s accepts an ADD -> ADD sequence unchanged.
REQ-032 SHALL cover: reset asserted during EXEC -> next cycle w=1, write never asserted.
REQ-033 SHALL cover: opcode 111 with the macro defined -> halt=1 held for 10 or more cycles until reset; without the macro -> w=1 two cycles after the accepting edge.
